// File: rtl/interfaz_io_vec.sv
// interfaz_io_vec: interrupt controller (edge-latched, masked, priority vector) plus port decoder. Optional IO_VEC_TIMEOUT_EN adds a SERVICE timeout.
// Latency: irq edge -> pending +1 cycle -> interrupt +2 cycles; ack -> vector/interrupt low +1 cycle; in_port/enable_out combinational.
// Backpressure: none; the core paces service with interrupt/interrupt_ack and an EOI write, and nothing nests.
module interfaz_io_vec #(
    parameter int          N_SRC       = 4,
    parameter int          N_OUT       = 3,
    parameter logic [7:0]  PORT_BASE   = 8'h30,
    parameter logic [7:0]  OUT_BASE    = 8'h00,
    parameter logic [6:0]  VEC_BASE    = 7'd100,
    parameter int          HOLD_CYCLES = 9
) (
    input  logic             reloj,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             write_strobe,
    input  logic             interrupt_ack,
    input  logic [7:0]       dato_ext,
    output logic [7:0]       in_port,
    output logic [N_OUT-1:0] enable_out,
    output logic             interrupt
);

    localparam logic [7:0] P_VEC  = PORT_BASE;
    localparam logic [7:0] P_STAT = PORT_BASE + 8'd1;
    localparam logic [7:0] P_MASK = PORT_BASE + 8'd2;

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t           state, state_nx;
    logic [N_SRC-1:0] pending, pending_nx, src_q, mask, rise, clr, active;
    logic [7:0]       vector, vector_nx;
    logic [7:0]       pend_ext, mask_ext, ctrl_off;
    logic [2:0]       id;
    logic             req, interrupt_nx, to_flag, to_flag_nx;
    logic             eoi_wr, mask_wr, ctrl_sel, hold_exp;

    assign rise     = irq_src & ~src_q;
    assign active   = pending & mask;
    assign req      = |active;
    assign eoi_wr   = write_strobe && (port_id == P_STAT);
    assign mask_wr  = write_strobe && (port_id == P_MASK);
    // Wrapping subtraction keeps the controller window test correct near 8'hFF.
    assign ctrl_off = port_id - PORT_BASE;
    assign ctrl_sel = (ctrl_off < 8'd4);
    // A new edge in the same cycle as the ack clear re-sets the bit.
    assign pending_nx = (pending & ~clr) | rise;

`ifdef IO_VEC_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    logic [CW-1:0] hold_cnt;

    assign hold_exp = (state == SERVICE) && (hold_cnt == CW'(HOLD_CYCLES - 1));

    // Cycles spent in SERVICE; parked at zero everywhere else.
    always_ff @(posedge reloj) begin
        if (!reset_n)              hold_cnt <= '0;
        else if (state == SERVICE) hold_cnt <= hold_cnt + 1'b1;
        else                       hold_cnt <= '0;
    end
`else
    assign hold_exp = 1'b0;
`endif

    // Lowest-numbered active source wins.
    always_comb begin
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) id = 3'(i);
        end
    end

    // Next-state, interrupt line, vector capture and pending clear.
    always_comb begin
        state_nx     = state;
        interrupt_nx = interrupt;
        vector_nx    = vector;
        clr          = '0;
        to_flag_nx   = to_flag;
        if (eoi_wr) to_flag_nx = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx     = ASSERT;
                    interrupt_nx = 1'b1;
                end
            end
            ASSERT: begin
                if (!req) begin
                    state_nx     = IDLE;
                    interrupt_nx = 1'b0;
                end else if (interrupt_ack) begin
                    state_nx     = SERVICE;
                    interrupt_nx = 1'b0;
                    vector_nx    = {1'b1, VEC_BASE + 7'(id)};
                    clr          = N_SRC'(1) << id;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_nx     = IDLE;
                    vector_nx[7] = 1'b0;
                end else if (hold_exp) begin
                    state_nx     = IDLE;
                    vector_nx[7] = 1'b0;
                    to_flag_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Register update; reset discards everything including pending events.
    always_ff @(posedge reloj) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            src_q     <= '0;
            mask      <= '1;
            vector    <= 8'h00;
            interrupt <= 1'b0;
            to_flag   <= 1'b0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            src_q     <= irq_src;
            if (mask_wr) mask <= N_SRC'(out_port);
            vector    <= vector_nx;
            interrupt <= interrupt_nx;
            to_flag   <= to_flag_nx;
        end
    end

    // Read-back mux; unknown addresses fall through to the external data.
    always_comb begin
        pend_ext              = '0;
        pend_ext[N_SRC-1:0]   = pending;
        mask_ext              = '0;
        mask_ext[N_SRC-1:0]   = mask;
        case (port_id)
            P_VEC:   in_port = vector;
            P_STAT:  in_port = {to_flag | pend_ext[7], pend_ext[6:0]};
            P_MASK:  in_port = mask_ext;
            default: in_port = dato_ext;
        endcase
    end

    // One-hot write enables; the controller window shadows any overlap.
    always_comb begin
        enable_out = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (write_strobe && !ctrl_sel && (port_id == OUT_BASE + 8'(k)))
                enable_out[k] = 1'b1;
        end
    end

endmodule
